unisim_sram_banked: RTL
=======================

# unisim_sram_banked

Parametrised 1-write/1-read banked SRAM for FPGA targets. It tiles `BRAM_16384x1`-class primitives horizontally (data width) and vertically (depth) for any DATA_W/DEPTH combination. It resolves same-address read/write collisions deterministically, flags out-of-range accesses, and optionally adds an output register stage. It sits between accelerator private local memory ports and the technology BRAM primitives, replacing the fixed-geometry generated wrappers.

## Interface
Parameters:
- DATA_W, 8: word width in bits.
- DEPTH, 1048576: number of words; need not be a power of two.
- BANK_AW, 14: primitive address width (bank depth 2^BANK_AW).
- BANK_DW, 1: primitive data width.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.

Derived values:
- ADDR_W = clog2(DEPTH).
- NH = ceil(DATA_W/BANK_DW) horizontal banks.
- NV = ceil(DEPTH/2^BANK_AW) vertical banks.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  reset; asynchronous, active-low.
- CE0  in  1  write-port enable.
- A0  in  ADDR_W  write address.
- D0  in  DATA_W  write data.
- WE0  in  1  write enable; qualified by CE0.
- WEM0  in  DATA_W  bit write mask; 1 means the bit is written.
- CE1  in  1  read-port enable.
- A1  in  ADDR_W  read address.
- Q1  out  DATA_W  read data.
- Q1_VALID  out  1  pulses when Q1 carries the data of a completed read.
- ERR  out  1  sticky; set on any out-of-range access, cleared only by reset.

## Operation
- Address split:
  - Vertical bank = A[ADDR_W-1:BANK_AW].
  - Bank address = A[BANK_AW-1:0].
  - Exactly one vertical row of NH banks is enabled per port per cycle.
- Horizontal slicing:
  - Bank hh takes bits [BANK_DW*hh +: BANK_DW].
  - If DATA_W is not a multiple of BANK_DW, the last bank's unused D/WEM bits are tied to 0 and its unused Q bits are dropped.
- Write: CE0&WE0 with A0<DEPTH writes the D0 bits selected by WEM0. Unselected bits are unchanged. CE0 with WE0=0 is a no-op.
- Read: CE1 with A1<DEPTH reads the word. The vertical select is registered on the CE1 cycle and steers the Q mux on the next cycle.
- Out-of-range: A0 or A1 >= DEPTH with its CE asserted is handled as follows:
  - No bank is enabled.
  - ERR is set the next cycle.
  - A read returns all-zero data, and Q1_VALID still pulses.
- Q1 holds its last value when no read completes.
- Collision: CE0&WE0&CE1 with A0==A1 in the same cycle. Behaviour depends on the Configuration macro.
- Each port drives its own primitive port, so different addresses in the same bank never conflict. Reads and writes to different addresses are fully concurrent.

## Timing
- Read latency is 1+OUT_REG cycles from the CE1 edge to Q1/Q1_VALID.
- Q1_VALID is a delayed copy of CE1; back-to-back reads give back-to-back valids.
- A write is visible to any read issued at least 1 cycle later.
- Reset values, applied immediately on RSTN low:
  - Q1=0, Q1_VALID=0, ERR=0.
  - Registered vertical select = 0; OUT_REG stage = 0; bypass state = 0.
- Bank contents are not reset.
- Reset mid-read: the in-flight read is dropped and no Q1_VALID is produced. The first read after RSTN rises completes normally.
- Inputs sampled while RSTN is low are ignored.

## Configuration
- SRAM_BANKED_WRITE_BYPASS_EN defined:
  - On a collision, the read returns the post-write word: (old & ~WEM0) | (D0 & WEM0).
  - The old word is taken from the read-first primitive output.
  - D0/WEM0 are captured in a bypass register on the collision cycle and merged at the Q mux.
  - No flag is raised.
- SRAM_BANKED_WRITE_BYPASS_EN undefined:
  - The read returns the pre-write word, which is the primitive's read-first output.
  - The write still occurs.
  - ERR is set, because collisions are illegal in this configuration.
  - Simulation builds print a conflict message but do not stop.

## Test plan
- Reset/idle: assert RSTN=0 mid-read, release it, then idle. Q1=0, Q1_VALID=0 and ERR=0 throughout, with no spurious valid.
- Cross-bank write/read, DATA_W=8, DEPTH=2^20:
  - Write 0xA5 at 0x00000 and 0x3C at 0xFC001, then read both back-to-back.
  - With OUT_REG=0, Q1 gives 0xA5 then 0x3C on consecutive cycles, 1 cycle after each CE1.
  - With OUT_REG=1, the same data arrives 2 cycles after each CE1.
- Masked write: preload 0xFF, write D0=0x00 with WEM0=0x0F, then read. Q1 = 0xF0.
- Collision: preload 0x11 at addr 5, then in one cycle write 0xEE with WEM0=0xFF and read addr 5.
  - With the macro: Q1=0xEE and ERR=0.
  - Without the macro: Q1=0x11 and ERR=1.
  - In both cases a later read returns 0xEE.
- Non-power-of-two geometry, DATA_W=12, DEPTH=20000, BANK_DW=1:
  - Write/read addr 19999 with 0xABC; Q1=0xABC.
  - Read addr 20000; Q1=0x000, Q1_VALID=1, ERR=1 the next cycle.
- Concurrency: a random 10k-cycle stream of non-colliding reads/writes across all banks, compared against a reference model. No mismatches and ERR=0.

Source files
------------

// File: rtl/unisim_sram_banked.sv
// unisim_sram_banked: 1W/1R SRAM tiled from read-first BANK_AW x BANK_DW banks.
// Define SRAM_BANKED_WRITE_BYPASS_EN to forward same-address writes into the read data.
module unisim_sram_banked #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 1048576,
    parameter int BANK_AW = 14,
    parameter int BANK_DW = 1,
    parameter int OUT_REG = 0,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CE0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    input  logic              WE0,
    input  logic [DATA_W-1:0] WEM0,
    input  logic              CE1,
    input  logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] Q1,
    output logic              Q1_VALID,
    output logic              ERR
);

    localparam int NH         = (DATA_W + BANK_DW - 1) / BANK_DW;
    localparam int BANK_WORDS = 1 << BANK_AW;
    localparam int NV         = (DEPTH + BANK_WORDS - 1) / BANK_WORDS;
    localparam int VSEL_W     = (NV > 1) ? $clog2(NV) : 1;
    localparam int PAD_W      = NH * BANK_DW;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic                       wr_ok;
    logic                       rd_ok;
    logic                       wr_go;
    logic                       rd_go;
    logic                       collide;
    logic                       coll_err;
    logic [VSEL_W-1:0]          wr_vsel;
    logic [VSEL_W-1:0]          rd_vsel;
    logic [BANK_AW-1:0]         wr_baddr;
    logic [BANK_AW-1:0]         rd_baddr;
    logic [PAD_W-1:0]           d_pad;
    logic [PAD_W-1:0]           wem_pad;
    logic [NV-1:0][PAD_W-1:0]   bank_q;
    logic                       rd_vld_r;
    logic                       rd_oor_r;
    logic [VSEL_W-1:0]          rd_vsel_r;
    logic [DATA_W-1:0]          rd_word;
    logic [DATA_W-1:0]          q_hold_r;

    assign wr_ok    = ({1'b0, A0} < DEPTH_C);
    assign rd_ok    = ({1'b0, A1} < DEPTH_C);
    assign wr_go    = RSTN & CE0 & WE0 & wr_ok;
    assign rd_go    = RSTN & CE1 & rd_ok;
    assign collide  = CE0 & WE0 & CE1 & rd_ok & (A0 == A1);
    assign wr_vsel  = VSEL_W'(A0 >> BANK_AW);
    assign rd_vsel  = VSEL_W'(A1 >> BANK_AW);
    assign wr_baddr = BANK_AW'(A0);
    assign rd_baddr = BANK_AW'(A1);
    assign d_pad    = PAD_W'(D0);
    assign wem_pad  = PAD_W'(WEM0);

    for (genvar vv = 0; vv < NV; vv++) begin : g_row
        logic wr_en;
        logic rd_en;
        assign wr_en = wr_go & (wr_vsel == VSEL_W'(vv));
        assign rd_en = rd_go & (rd_vsel == VSEL_W'(vv));
        for (genvar hh = 0; hh < NH; hh++) begin : g_col
            logic [BANK_DW-1:0] mem [BANK_WORDS];
            logic [BANK_DW-1:0] q_r;
            // Read-first bank: a same-cycle write to the read address is not seen on q_r.
            always_ff @(posedge CLK) begin
                if (wr_en) begin
                    for (int b = 0; b < BANK_DW; b++) begin
                        if (wem_pad[hh*BANK_DW + b]) begin
                            mem[wr_baddr][b] <= d_pad[hh*BANK_DW + b];
                        end
                    end
                end
                if (rd_en) begin
                    q_r <= mem[rd_baddr];
                end
            end
            assign bank_q[vv][hh*BANK_DW +: BANK_DW] = q_r;
        end
    end

`ifdef SRAM_BANKED_WRITE_BYPASS_EN
    logic              byp_hit_r;
    logic [DATA_W-1:0] byp_d_r;
    logic [DATA_W-1:0] byp_m_r;

    assign coll_err = 1'b0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            byp_hit_r <= 1'b0;
            byp_d_r   <= '0;
            byp_m_r   <= '0;
        end else begin
            byp_hit_r <= collide;
            if (collide) begin
                byp_d_r <= D0;
                byp_m_r <= WEM0;
            end
        end
    end
`else
    assign coll_err = collide;
`endif

    always_comb begin
        rd_word = rd_oor_r ? '0 : bank_q[rd_vsel_r][DATA_W-1:0];
`ifdef SRAM_BANKED_WRITE_BYPASS_EN
        if (byp_hit_r) begin
            rd_word = (rd_word & ~byp_m_r) | (byp_d_r & byp_m_r);
        end
`endif
    end

    // An out-of-range read still completes (as zero data) so the valid stream mirrors CE1.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_vld_r  <= 1'b0;
            rd_oor_r  <= 1'b0;
            rd_vsel_r <= '0;
            q_hold_r  <= '0;
            ERR       <= 1'b0;
        end else begin
            rd_vld_r <= CE1;
            rd_oor_r <= CE1 & ~rd_ok;
            if (rd_go) begin
                rd_vsel_r <= rd_vsel;
            end
            if (rd_vld_r) begin
                q_hold_r <= rd_word;
            end
            if ((CE0 & ~wr_ok) | (CE1 & ~rd_ok) | coll_err) begin
                ERR <= 1'b1;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic out_vld_r;
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                out_vld_r <= 1'b0;
            end else begin
                out_vld_r <= rd_vld_r;
            end
        end
        assign Q1       = q_hold_r;
        assign Q1_VALID = out_vld_r;
    end else begin : g_noreg
        assign Q1       = rd_vld_r ? rd_word : q_hold_r;
        assign Q1_VALID = rd_vld_r;
    end

endmodule
